// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC sequencer driving the imem read handshake and iq enqueue
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched/perf_discarded counters.

module fetch_pc_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 'h00000060
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_read,
   output logic [WIDTH-1:0] imem_address,
   input  logic             imem_resp,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             iq_full,
   output logic             iq_enq,
   output logic [WIDTH-1:0] iq_instr,
   output logic [WIDTH-1:0] iq_pc,
   input  logic             flush,
   input  logic [WIDTH-1:0] flush_pc,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic [WIDTH-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_discarded
`endif
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] req_q, req_d;
   logic [WIDTH-1:0] hold_instr, hold_pc;
   logic             enq, park, drop;
   logic [WIDTH-1:0] enq_instr, enq_pc;
   logic             tgt;
   logic [WIDTH-1:0] tgt_pc;

   assign tgt          = flush | redirect;
   assign tgt_pc       = flush ? flush_pc : redirect_pc;
   assign imem_read    = !rst && (state_q != S_HOLD);
   assign imem_address = req_q;
   assign fetch_pc     = pc_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_d     = req_q;
      enq       = 1'b0;
      enq_instr = imem_rdata;
      enq_pc    = req_q;
      park      = 1'b0;
      drop      = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_resp) begin
               if (tgt) begin
                  drop  = 1'b1;
                  pc_d  = tgt_pc;
                  req_d = tgt_pc;
               end else if (iq_full) begin
                  park    = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  enq   = 1'b1;
                  pc_d  = pc_q + WIDTH'(4);
                  req_d = pc_q + WIDTH'(4);
               end
            end else if (tgt) begin
               // request already on the bus must finish before the new target is fetched
               pc_d    = tgt_pc;
               state_d = S_DISCARD;
            end
         end
         S_HOLD: begin
            if (tgt) begin
               drop    = 1'b1;
               pc_d    = tgt_pc;
               req_d   = tgt_pc;
               state_d = S_FETCH;
            end else if (!iq_full) begin
               enq       = 1'b1;
               enq_instr = hold_instr;
               enq_pc    = hold_pc;
               pc_d      = pc_q + WIDTH'(4);
               req_d     = pc_q + WIDTH'(4);
               state_d   = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (tgt) pc_d = tgt_pc;
            if (imem_resp) begin
               drop    = 1'b1;
               req_d   = tgt ? tgt_pc : pc_q;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         req_q      <= RESET_PC;
         hold_instr <= '0;
         hold_pc    <= '0;
         iq_enq     <= 1'b0;
         iq_instr   <= '0;
         iq_pc      <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         if (park) begin
            hold_instr <= imem_rdata;
            hold_pc    <= req_q;
         end
         iq_enq <= enq;
         if (enq) begin
            iq_instr <= enq_instr;
            iq_pc    <= enq_pc;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched   <= '0;
         perf_discarded <= '0;
      end else begin
         if (iq_enq && perf_fetched != 32'hFFFFFFFF) perf_fetched <= perf_fetched + 32'd1;
         if (drop && perf_discarded != 32'hFFFFFFFF) perf_discarded <= perf_discarded + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed and randomized bench for fetch_pc_ctrl against a fetch-stream model
module tb_fetch_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        iq_full = 1'b0;
   logic        iq_enq;
   logic [31:0] iq_instr, iq_pc;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_discarded;
`endif

   fetch_pc_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .iq_full(iq_full), .iq_enq(iq_enq), .iq_instr(iq_instr), .iq_pc(iq_pc),
      .flush(flush), .flush_pc(flush_pc),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // memory model: latches the address at request start, answers after lat cycles (lat<0: random 0..2)
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          lat;

   // fetch-stream model
   logic [31:0] m_pc, m_req, m_ppc, m_pins;
   bit          m_parked, m_stale;
   logic        e_enq;
   logic [31:0] e_pc, e_ins;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic model_reset();
      m_pc = 32'h60; m_req = 32'h60; m_parked = 0; m_stale = 0;
      m_ppc = '0; m_pins = '0;
      e_enq = 0; e_pc = '0; e_ins = '0;
      mem_busy = 0; mem_wait = 0; mem_addr = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_resp = 0; iq_full = 0; flush = 0; redirect = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   // one clock: memory answers, inputs are driven, the model advances, outputs settle
   task automatic step(input logic f, input logic fl, input logic [31:0] fpc,
                       input logic rd, input logic [31:0] rpc);
      logic        r;
      logic [31:0] d, t;
      logic        tg;
      r = 0; d = '0;
      if (imem_read) begin
         if (!mem_busy) begin
            mem_busy = 1; mem_addr = imem_address;
            mem_wait = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
         end
         if (mem_wait == 0) begin
            r = 1; d = mem_word(mem_addr); mem_busy = 0;
         end else mem_wait--;
      end
      imem_resp = r; imem_rdata = d; iq_full = f;
      flush = fl; flush_pc = fpc; redirect = rd; redirect_pc = rpc;
      tg = fl | rd;
      t  = fl ? fpc : rpc;
      e_enq = 0;
      if (m_parked) begin
         if (tg) begin m_parked = 0; m_pc = t; m_req = t; end
         else if (!f) begin
            e_enq = 1; e_pc = m_ppc; e_ins = m_pins; m_parked = 0;
            m_pc = m_pc + 4; m_req = m_pc;
         end
      end else if (m_stale) begin
         if (tg) m_pc = t;
         if (r) begin m_stale = 0; m_req = m_pc; end
      end else if (r) begin
         if (tg) begin m_pc = t; m_req = t; end
         else if (f) begin m_parked = 1; m_ppc = m_req; m_pins = d; end
         else begin
            e_enq = 1; e_pc = m_req; e_ins = d; m_pc = m_pc + 4; m_req = m_pc;
         end
      end else if (tg) begin
         m_pc = t; m_stale = 1;
      end
      @(posedge clk); #1;
      imem_resp = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (imem_read !== 1'b0) $display("FAIL rst_read: got %b want 0", imem_read); else n_pass++;
      n_checks++; if (imem_address !== 32'h60) $display("FAIL rst_addr: got %h want 00000060", imem_address); else n_pass++;
      n_checks++; if (fetch_pc !== 32'h60) $display("FAIL rst_fetch_pc: got %h want 00000060", fetch_pc); else n_pass++;
      n_checks++; if (iq_enq !== 1'b0) $display("FAIL rst_enq: got %b want 0", iq_enq); else n_pass++;
      n_checks++; if (iq_pc !== 32'h0) $display("FAIL rst_iq_pc: got %h want 0", iq_pc); else n_pass++;
      n_checks++; if (iq_instr !== 32'h0) $display("FAIL rst_iq_instr: got %h want 0", iq_instr); else n_pass++;
      rst = 1'b0; model_reset(); #1;
      n_checks++; if (imem_read !== 1'b1) $display("FAIL rst_first_req: got %b want 1", imem_read); else n_pass++;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_a [3];
      logic [31:0] got_a [3];
      logic [31:0] got_p [3];
      logic [31:0] got_i [3];
      int na, ne;
      exp_a = '{32'h60, 32'h64, 32'h68};
      na = 0; ne = 0;
      do_reset(); lat = 1;
      for (int i = 0; i < 30; i++) begin
         if (imem_read && !mem_busy && na < 3) begin got_a[na] = imem_address; na++; end
         step(0, 0, 0, 0, 0);
         if (iq_enq && ne < 3) begin got_p[ne] = iq_pc; got_i[ne] = iq_instr; ne++; end
      end
      n_checks++; if (ne !== 3 || na !== 3) $display("FAIL seq_count: got %0d/%0d want 3/3", na, ne); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (got_a[k] !== exp_a[k]) $display("FAIL seq_addr%0d: got %h want %h", k, got_a[k], exp_a[k]); else n_pass++;
         n_checks++; if (got_p[k] !== exp_a[k]) $display("FAIL seq_iq_pc%0d: got %h want %h", k, got_p[k], exp_a[k]); else n_pass++;
         n_checks++; if (got_i[k] !== mem_word(exp_a[k])) $display("FAIL seq_instr%0d: got %h want %h", k, got_i[k], mem_word(exp_a[k])); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int i;
      do_reset(); lat = 1;
      for (i = 0; i < 30 && !(imem_read && imem_address == 32'h64 && mem_busy && mem_wait == 0); i++) step(0, 0, 0, 0, 0);
      n_checks++; if (i >= 30) $display("FAIL bp_reach: got timeout want resp for 00000064"); else n_pass++;
      step(1, 0, 0, 0, 0);
      repeat (3) begin
         n_checks++; if (imem_read !== 1'b0) $display("FAIL bp_read_low: got %b want 0", imem_read); else n_pass++;
         n_checks++; if (iq_enq !== 1'b0) $display("FAIL bp_no_enq: got %b want 0", iq_enq); else n_pass++;
         step(1, 0, 0, 0, 0);
      end
      n_checks++; if (imem_read !== 1'b0) $display("FAIL bp_read_low_last: got %b want 0", imem_read); else n_pass++;
      step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b1) $display("FAIL bp_enq: got %b want 1", iq_enq); else n_pass++;
      n_checks++; if (iq_pc !== 32'h64) $display("FAIL bp_iq_pc: got %h want 00000064", iq_pc); else n_pass++;
      n_checks++; if (iq_instr !== mem_word(32'h64)) $display("FAIL bp_instr: got %h want %h", iq_instr, mem_word(32'h64)); else n_pass++;
      n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h68) $display("FAIL bp_next_req: got %b/%h want 1/00000068", imem_read, imem_address); else n_pass++;
   endtask

   task automatic test_flush_outstanding();
      int i;
      do_reset(); lat = 2;
      for (i = 0; i < 60 && !(imem_read && imem_address == 32'h70 && mem_busy); i++) step(0, 0, 0, 0, 0);
      n_checks++; if (i >= 60) $display("FAIL fo_reach: got timeout want request 00000070"); else n_pass++;
      step(0, 1, 32'h200, 0, 0);
      n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h70) $display("FAIL fo_addr_stable: got %b/%h want 1/00000070", imem_read, imem_address); else n_pass++;
      n_checks++; if (fetch_pc !== 32'h200) $display("FAIL fo_fetch_pc: got %h want 00000200", fetch_pc); else n_pass++;
      step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b0) $display("FAIL fo_drop: got %b want 0", iq_enq); else n_pass++;
      n_checks++; if (imem_address !== 32'h200) $display("FAIL fo_new_req: got %h want 00000200", imem_address); else n_pass++;
      for (i = 0; i < 20 && !iq_enq; i++) step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b1 || iq_pc !== 32'h200) $display("FAIL fo_first_pc: got %b/%h want 1/00000200", iq_enq, iq_pc); else n_pass++;
   endtask

   task automatic test_flush_at_resp();
      int i;
      do_reset(); lat = 1;
      for (i = 0; i < 30 && !(imem_read && imem_address == 32'h68 && mem_busy && mem_wait == 0); i++) step(0, 0, 0, 0, 0);
      n_checks++; if (i >= 30) $display("FAIL fr_reach: got timeout want resp for 00000068"); else n_pass++;
      step(0, 1, 32'h300, 1, 32'h400);
      n_checks++; if (iq_enq !== 1'b0) $display("FAIL fr_drop: got %b want 0", iq_enq); else n_pass++;
      n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h300) $display("FAIL fr_next_req: got %b/%h want 1/00000300", imem_read, imem_address); else n_pass++;
      for (i = 0; i < 20 && !iq_enq; i++) step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b1 || iq_pc !== 32'h300) $display("FAIL fr_first_pc: got %b/%h want 1/00000300", iq_enq, iq_pc); else n_pass++;
   endtask

   task automatic test_wrap();
      int i;
      do_reset(); lat = 1;
      for (i = 0; i < 30 && !(imem_read && mem_busy && mem_wait == 0); i++) step(0, 0, 0, 0, 0);
      step(0, 1, 32'hFFFFFFFC, 0, 0);
      n_checks++; if (imem_address !== 32'hFFFFFFFC) $display("FAIL wrap_req: got %h want fffffffc", imem_address); else n_pass++;
      for (i = 0; i < 20 && !iq_enq; i++) step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b1 || iq_pc !== 32'hFFFFFFFC) $display("FAIL wrap_enq: got %b/%h want 1/fffffffc", iq_enq, iq_pc); else n_pass++;
      n_checks++; if (imem_address !== 32'h0 || fetch_pc !== 32'h0) $display("FAIL wrap_next: got %h/%h want 0/0", imem_address, fetch_pc); else n_pass++;
   endtask

   task automatic test_async_reset();
      int i;
      do_reset(); lat = 1;
      repeat (8) step(0, 0, 0, 0, 0);
      lat = 3;
      for (i = 0; i < 30 && !(imem_read && mem_busy && mem_wait >= 1); i++) step(0, 0, 0, 0, 0);
      step(0, 1, 32'h500, 0, 0);
      n_checks++; if (fetch_pc !== 32'h500 || imem_read !== 1'b1) $display("FAIL ar_discard: got %h/%b want 00000500/1", fetch_pc, imem_read); else n_pass++;
      rst = 1'b1;
      #2;
      n_checks++; if (imem_read !== 1'b0) $display("FAIL ar_read: got %b want 0", imem_read); else n_pass++;
      n_checks++; if (imem_address !== 32'h60 || fetch_pc !== 32'h60) $display("FAIL ar_pc: got %h/%h want 00000060/00000060", imem_address, fetch_pc); else n_pass++;
      n_checks++; if (iq_enq !== 1'b0 || iq_pc !== 32'h0 || iq_instr !== 32'h0) $display("FAIL ar_iq: got %b/%h/%h want 0/0/0", iq_enq, iq_pc, iq_instr); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0; model_reset(); lat = 1; #1;
      n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h60) $display("FAIL ar_first_req: got %b/%h want 1/00000060", imem_read, imem_address); else n_pass++;
      for (i = 0; i < 20 && !iq_enq; i++) step(0, 0, 0, 0, 0);
      n_checks++; if (iq_enq !== 1'b1 || iq_pc !== 32'h60) $display("FAIL ar_first_enq: got %b/%h want 1/00000060", iq_enq, iq_pc); else n_pass++;
   endtask

   task automatic test_random();
      logic        f, fl, rd;
      logic [31:0] fpc, rpc;
      do_reset(); lat = -1;
      for (int c = 0; c < 1500; c++) begin
         f   = ($urandom_range(0, 99) < 30);
         fl  = ($urandom_range(0, 99) < 4);
         rd  = ($urandom_range(0, 99) < 8);
         fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFFFFFC);
         rpc = $urandom & 32'h0000FFFC;
         step(f, fl, fpc, rd, rpc);
         n_checks++; if (imem_read !== !m_parked) $display("FAIL rnd_read c%0d: got %b want %b", c, imem_read, !m_parked); else n_pass++;
         if (imem_read) begin
            n_checks++; if (imem_address !== m_req) $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_address, m_req); else n_pass++;
         end
         n_checks++; if (fetch_pc !== m_pc) $display("FAIL rnd_fetch_pc c%0d: got %h want %h", c, fetch_pc, m_pc); else n_pass++;
         n_checks++; if (iq_enq !== e_enq) $display("FAIL rnd_enq c%0d: got %b want %b", c, iq_enq, e_enq); else n_pass++;
         if (e_enq) begin
            n_checks++; if (iq_pc !== e_pc || iq_instr !== e_ins) $display("FAIL rnd_entry c%0d: got %h/%h want %h/%h", c, iq_pc, iq_instr, e_pc, e_ins); else n_pass++;
         end
      end
   endtask

   initial begin
      lat = 1;
      model_reset();
      test_reset();
      test_sequential();
      test_backpressure();
      test_flush_outstanding();
      test_flush_at_resp();
      test_wrap();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage sequencer that owns the architectural fetch PC and drives the instruction-memory read handshake.
- Advances the PC by 4 on each completed fetch and enqueues {instr, pc} into the instruction queue.
- Applies back-pressure when the queue is full.
- Accepts redirects from ROB flush (highest priority) and decode-stage jumps, and discards stale in-flight responses.

Parameters:
- WIDTH, 32, PC/address/data width.
- RESET_PC, 32'h00000060, PC value loaded on reset.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- imem_read  output  1  instruction read request; held high until imem_resp
- imem_address  output  WIDTH  read address; stable while imem_read=1
- imem_resp  input  1  one-cycle response strobe
- imem_rdata  input  WIDTH  instruction word, valid with imem_resp
- iq_full  input  1  instruction queue cannot accept this cycle
- iq_enq  output  1  enqueue strobe (registered)
- iq_instr  output  WIDTH  instruction for enqueue
- iq_pc  output  WIDTH  PC of iq_instr
- flush  input  1  ROB mispredict/exception flush
- flush_pc  input  WIDTH  flush target
- redirect  input  1  decode-stage redirect (JAL etc.)
- redirect_pc  input  WIDTH  redirect target
- fetch_pc  output  WIDTH  current fetch PC

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - iq_enq=0, iq_instr=0, iq_pc=0, hold buffer cleared.
  - imem_read is 0 while rst is high. The first request is issued in the first cycle after deassertion.
- Registers:
  - pc: next PC to fetch.
  - req_addr: address of the outstanding request.
  - hold_instr/hold_pc: parked response.
  - iq_* output registers.
- imem_address=req_addr always. req_addr<=pc on every cycle a new request starts: FETCH with no outstanding request, and the cycle after any completion.
- States:
  - FETCH:
    - imem_read=1.
    - On imem_resp with no flush/redirect and iq_full=0: register iq_instr=imem_rdata, iq_pc=req_addr, iq_enq=1 next cycle (1-cycle pulse). Then pc<=pc+4 (mod 2^WIDTH, wrap silently), stay FETCH.
    - On imem_resp with iq_full=1: capture into hold buffer, go HOLD, imem_read=0.
  - HOLD:
    - imem_read=0.
    - When iq_full=0: enqueue hold buffer (iq_enq pulse next cycle), pc<=pc+4, go FETCH.
  - DISCARD:
    - imem_read=1 at stale req_addr until imem_resp. Response data is dropped; no enqueue.
    - On imem_resp go FETCH; the new request uses the updated pc.
- Redirect priority: flush > redirect > sequential. A simultaneous redirect is ignored when flush=1.
- Redirect with target T (flush_pc or redirect_pc):
  - pc<=T.
  - FETCH, no imem_resp this cycle: go DISCARD; req_addr unchanged.
  - FETCH, imem_resp this cycle: drop data, stay FETCH; next request at T.
  - HOLD: drop hold buffer, go FETCH.
  - DISCARD: stay DISCARD; pc<=T (latest target wins).
  - An iq_enq already registered for the following cycle is still emitted. The queue owner clears on flush; decode owns redirect squash.
- iq_enq is never asserted in a cycle where iq_full was 1 in the preceding decision cycle. iq_enq is at most one pulse per completed fetch.
- fetch_pc=pc (combinational from register).
- imem_address never changes while imem_read=1 and imem_resp=0.
- Reset mid-operation: immediate return to reset values. An outstanding memory response after reset is treated as the response to the new RESET_PC request; the memory is reset by the same rst.

Optional Feature:
- FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_discarded (32).
  - perf_fetched increments on each iq_enq.
  - perf_discarded increments on each dropped response: DISCARD resp, resp coincident with redirect, or hold buffer dropped.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, memory responds 1 cycle after every request, iq_full=0 -> imem_address sequence 0x60,0x64,0x68; iq_enq pulses with iq_pc=0x60,0x64,0x68 and matching iq_instr.
- iq_full=1 at response for addr 0x64, held 3 cycles -> imem_read low for those cycles; iq_enq with iq_pc=0x64 one cycle after iq_full drops; next request 0x68.
- flush=1, flush_pc=0x200 while request 0x70 outstanding, response 2 cycles later -> imem_address stays 0x70 until resp; data dropped; next request 0x200; first iq_pc=0x200.
- flush (0x300) and redirect (0x400) same cycle as imem_resp -> response dropped, next request 0x300, no iq_enq for the dropped word.
- pc=32'hFFFFFFFC fetch completes -> next request address 0x00000000.
- Assert rst asynchronously mid-DISCARD -> outputs zero/RESET_PC immediately without a clock edge; after release, first request at 0x60.
